// File: rtl/eth_tx_sf_buffer.sv
// eth_tx_sf_buffer
//   Store-and-forward packet buffer in front of the 100G MAC TX Avalon-ST sink.
//   User packets, which may contain bubbles, are written into a word buffer.
//   A packet is released to the MAC only once its EOP has been stored. The MAC
//   therefore sees valid held continuously from SOP to EOP.
//   Malformed input is handled as follows:
//     - a non-SOP beat while idle is discarded;
//     - an SOP inside a packet closes the stored part of that packet with error;
//     - a packet longer than the buffer is truncated with error.
//   Discarded beats are counted in a saturating counter.
// Ports
//   i_clk_tx, i_tx_reset            clock, synchronous active-high reset
//   i_in_*, o_in_ready              upstream Avalon-ST sink (ready latency 0)
//   i_tx_ready, o_tx_*              MAC TX Avalon-ST source (registered outputs)
//   o_drop_count                    discarded input beats, saturating at 16'hFFFF
//   o_tx_frames                     EOP transfers to the MAC (32-bit wrap)
// Build option
//   ETH_TX_SF_STATS_EN : when defined, o_tx_frames counts frames sent;
//                        when undefined, o_tx_frames is tied to 0.
module eth_tx_sf_buffer #(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6,
  parameter int DEPTH   = 64
) (
  input  logic               i_clk_tx,
  input  logic               i_tx_reset,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [DATA_W-1:0]  i_in_data,
  input  logic               i_in_startofpacket,
  input  logic               i_in_endofpacket,
  input  logic [EMPTY_W-1:0] i_in_empty,
  input  logic               i_in_error,
  input  logic               i_tx_ready,
  output logic               o_tx_valid,
  output logic [DATA_W-1:0]  o_tx_data,
  output logic               o_tx_startofpacket,
  output logic               o_tx_endofpacket,
  output logic [EMPTY_W-1:0] o_tx_empty,
  output logic               o_tx_error,
  output logic [15:0]        o_drop_count,
  output logic [31:0]        o_tx_frames
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int SBW = EMPTY_W + 3;  // {sop, eop, empty, error}

  typedef enum logic [1:0] {WIDLE, WPKT, WDROP} wstate_e;
  typedef enum logic       {RIDLE, RSEND}       rstate_e;

  // Payload and sideband are kept in separate arrays so that closing a packet
  // only rewrites the narrow sideband of the last stored word.
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [SBW-1:0]    mem_sb   [DEPTH];

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  logic [PW-1:0] wr_ptr_q, rd_ptr_q, pkt_cnt_q, pkt_cnt_d;
  logic [15:0]   drop_q;

  logic               tx_valid_q, tx_sop_q, tx_eop_q, tx_err_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic [EMPTY_W-1:0] tx_empty_q;

  logic          full, acc, commit, dwe, swe, drop_inc;
  logic [AW-1:0] wr_addr, rd_addr, last_addr, sw_addr;
  logic [SBW-1:0] sw_val, sb_last, close_val, rd_sb;
  logic [DATA_W-1:0] rd_data;
  logic          tx_xfer, eop_xfer, load, clr;

  assign wr_addr   = wr_ptr_q[AW-1:0];
  assign rd_addr   = rd_ptr_q[AW-1:0];
  assign last_addr = wr_addr - AW'(1);
  assign full      = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign sb_last   = mem_sb[last_addr];
  // Closing a packet early: force EOP and error, keep the SOP flag
  // (the stored part may be a single word).
  assign close_val = {sb_last[SBW-1], 1'b1, {EMPTY_W{1'b0}}, 1'b1};

  assign o_in_ready = (wstate_q == WDROP) ? 1'b1 : !full;
  assign acc        = i_in_valid && o_in_ready;

  // ---------------- write side ----------------
  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    dwe      = 1'b0;
    swe      = 1'b0;
    sw_addr  = wr_addr;
    sw_val   = {i_in_startofpacket, i_in_endofpacket, i_in_empty, i_in_error};
    drop_inc = 1'b0;
    case (wstate_q)
      WIDLE: begin
        if (acc) begin
          if (i_in_startofpacket) begin
            dwe = 1'b1;
            swe = 1'b1;
            if (i_in_endofpacket) commit = 1'b1;
            else                  wstate_d = WPKT;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      WPKT: begin
        if (full && pkt_cnt_q == '0) begin
          // Whole buffer holds one unfinished packet: truncate it.
          swe      = 1'b1;
          sw_addr  = last_addr;
          sw_val   = close_val;
          commit   = 1'b1;
          wstate_d = WDROP;
        end else if (acc) begin
          if (i_in_startofpacket) begin
            swe      = 1'b1;
            sw_addr  = last_addr;
            sw_val   = close_val;
            commit   = 1'b1;
            drop_inc = 1'b1;
            wstate_d = i_in_endofpacket ? WIDLE : WDROP;
          end else begin
            dwe = 1'b1;
            swe = 1'b1;
            if (i_in_endofpacket) begin
              commit   = 1'b1;
              wstate_d = WIDLE;
            end
          end
        end
      end
      WDROP: begin
        if (acc) begin
          drop_inc = 1'b1;
          if (i_in_endofpacket) wstate_d = WIDLE;
        end
      end
      default: wstate_d = WIDLE;
    endcase
  end

  // ---------------- read side ----------------
  assign tx_xfer   = tx_valid_q && i_tx_ready;
  assign eop_xfer  = tx_xfer && tx_eop_q;
  assign pkt_cnt_d = pkt_cnt_q + PW'(commit) - PW'(eop_xfer);

  // The next word may be written in the same cycle it is fetched (a one-word
  // packet committing as the previous EOP leaves), so bypass the write port.
  assign rd_data = (dwe && wr_addr == rd_addr) ? i_in_data : mem_data[rd_addr];
  assign rd_sb   = (swe && sw_addr == rd_addr) ? sw_val    : mem_sb[rd_addr];

  always_comb begin
    rstate_d = rstate_q;
    load     = 1'b0;
    clr      = 1'b0;
    case (rstate_q)
      RIDLE: begin
        if (pkt_cnt_q != '0) begin
          load     = 1'b1;
          rstate_d = RSEND;
        end
      end
      RSEND: begin
        if (tx_xfer) begin
          if (!tx_eop_q || pkt_cnt_d != '0) begin
            load = 1'b1;
          end else begin
            clr      = 1'b1;
            rstate_d = RIDLE;
          end
        end
      end
      default: rstate_d = RIDLE;
    endcase
  end

  // ---------------- storage ----------------
  always_ff @(posedge i_clk_tx) begin
    if (dwe) mem_data[wr_addr] <= i_in_data;
    if (swe) mem_sb[sw_addr]   <= sw_val;
  end

  always_ff @(posedge i_clk_tx) begin
    if (i_tx_reset) begin
      wstate_q   <= WIDLE;
      rstate_q   <= RIDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      drop_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_empty_q <= '0;
      tx_err_q   <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      rstate_q  <= rstate_d;
      pkt_cnt_q <= pkt_cnt_d;
      if (dwe)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (load) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= rd_data;
        tx_sop_q   <= rd_sb[SBW-1];
        tx_eop_q   <= rd_sb[SBW-2];
        tx_empty_q <= rd_sb[SBW-3:1];
        tx_err_q   <= rd_sb[0];
      end else if (clr) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign o_tx_valid         = tx_valid_q;
  assign o_tx_data          = tx_data_q;
  assign o_tx_startofpacket = tx_sop_q;
  assign o_tx_endofpacket   = tx_eop_q;
  assign o_tx_empty         = tx_empty_q;
  assign o_tx_error         = tx_err_q;
  assign o_drop_count       = drop_q;

`ifdef ETH_TX_SF_STATS_EN
  logic [31:0] frames_q;
  always_ff @(posedge i_clk_tx) begin
    if (i_tx_reset)    frames_q <= '0;
    else if (eop_xfer) frames_q <= frames_q + 32'd1;
  end
  assign o_tx_frames = frames_q;
`else
  assign o_tx_frames = '0;
`endif

endmodule

// File: tb/tb_eth_tx_sf_buffer.sv
module tb_eth_tx_sf_buffer;

  localparam int DATA_W  = 512;
  localparam int EMPTY_W = 6;
  localparam int DEPTH   = 16;

  logic               clk;
  logic               i_tx_reset;
  logic               i_in_valid, o_in_ready;
  logic [DATA_W-1:0]  i_in_data;
  logic               i_in_startofpacket, i_in_endofpacket, i_in_error;
  logic [EMPTY_W-1:0] i_in_empty;
  logic               i_tx_ready, o_tx_valid;
  logic [DATA_W-1:0]  o_tx_data;
  logic               o_tx_startofpacket, o_tx_endofpacket, o_tx_error;
  logic [EMPTY_W-1:0] o_tx_empty;
  logic [15:0]        o_drop_count;
  logic [31:0]        o_tx_frames;

  eth_tx_sf_buffer #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .DEPTH(DEPTH)) dut (
    .i_clk_tx(clk), .i_tx_reset(i_tx_reset),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .i_in_startofpacket(i_in_startofpacket), .i_in_endofpacket(i_in_endofpacket),
    .i_in_empty(i_in_empty), .i_in_error(i_in_error),
    .i_tx_ready(i_tx_ready), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
    .o_tx_startofpacket(o_tx_startofpacket), .o_tx_endofpacket(o_tx_endofpacket),
    .o_tx_empty(o_tx_empty), .o_tx_error(o_tx_error),
    .o_drop_count(o_drop_count), .o_tx_frames(o_tx_frames)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DATA_W-1:0]  d;
    logic               s, e;
    logic [EMPTY_W-1:0] emp;
    logic               err;
  } beat_t;

  beat_t sb[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'hC0DE_0000 | 32'(k);
    return {16{w}};
  endfunction

  task automatic push(input int k, input logic s, input logic e, input logic [EMPTY_W-1:0] emp, input logic err);
    beat_t b;
    b.d = pat(k); b.s = s; b.e = e; b.emp = emp; b.err = err;
    sb.push_back(b);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int k, input logic s, input logic e, input logic [EMPTY_W-1:0] emp, input logic err);
    logic rdy;
    int n = 0;
    i_in_valid = 1'b1; i_in_data = pat(k);
    i_in_startofpacket = s; i_in_endofpacket = e; i_in_empty = emp; i_in_error = err;
    forever begin
      @(negedge clk); rdy = o_in_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin chk("in_ready_timeout", 0, 1); break; end
    end
    #1 i_in_valid = 1'b0;
    i_in_startofpacket = 1'b0; i_in_endofpacket = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
    chk("drain", DATA_W'(sb.size()), 0);
    idle(2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 i_tx_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 i_tx_reset = 1'b0;
    sb.delete();
  endtask

  task automatic wait_sop();
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(o_tx_valid && o_tx_startofpacket) && n < 100);
    if (n >= 100) chk("sop_timeout", 0, 1);
  endtask

  // Monitor: pops and compares every MAC-side transfer, and checks that valid
  // never drops between SOP and EOP.
  logic in_pkt = 1'b0;
  always @(negedge clk) begin
    if (i_tx_reset) begin
      in_pkt = 1'b0;
    end else begin
      if (in_pkt) chk("valid_gap", DATA_W'(o_tx_valid), 1);
      if (o_tx_valid && i_tx_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", DATA_W'(o_tx_valid), 0);
        end else begin
          beat_t b;
          b = sb.pop_front();
          chk("beat_data", o_tx_data, b.d);
          chk("beat_sop_eop_empty_err",
              DATA_W'({o_tx_startofpacket, o_tx_endofpacket, o_tx_empty, o_tx_error}),
              DATA_W'({b.s, b.e, b.emp, b.err}));
        end
        if (o_tx_startofpacket) in_pkt = 1'b1;
        if (o_tx_endofpacket)   in_pkt = 1'b0;
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] held;
    i_tx_reset = 1'b1; i_in_valid = 1'b0; i_in_data = '0;
    i_in_startofpacket = 1'b0; i_in_endofpacket = 1'b0; i_in_empty = '0; i_in_error = 1'b0;
    i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 i_tx_reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_tx_valid", DATA_W'(o_tx_valid), 0);
    chk("rst_in_ready", DATA_W'(o_in_ready), 1);
    chk("rst_drop", DATA_W'(o_drop_count), 0);
    chk("rst_frames", DATA_W'(o_tx_frames), 0);
    chk("rst_tx_side", DATA_W'({o_tx_startofpacket, o_tx_endofpacket, o_tx_empty, o_tx_error}), 0);
    @(posedge clk); #1;

    // 3-beat packet with a bubble after beat 2; valid appears 2 cycles after EOP
    push(1, 1, 0, 0, 0); push(2, 0, 0, 0, 0); push(3, 0, 1, 5, 0);
    send(1, 1, 0, 0, 0);
    send(2, 0, 0, 0, 0);
    idle(1);
    send(3, 0, 1, 5, 0);
    @(negedge clk); chk("lat_cycle1_valid", DATA_W'(o_tx_valid), 0);
    @(negedge clk); chk("lat_cycle2_valid", DATA_W'(o_tx_valid), 1);
    drain();

    // two 2-beat packets, MAC stall of 5 cycles inside packet 1
    push(10, 1, 0, 0, 0); push(11, 0, 1, 2, 0);
    push(12, 1, 0, 0, 0); push(13, 0, 1, 9, 1);
    fork
      begin
        send(10, 1, 0, 0, 0); send(11, 0, 1, 2, 0);
        send(12, 1, 0, 0, 0); send(13, 0, 1, 9, 1);
      end
      begin
        int n;
        wait_sop();
        @(posedge clk); #1 i_tx_ready = 1'b0;
        @(negedge clk);
        held = o_tx_data;
        chk("stall_eop_held", DATA_W'(o_tx_endofpacket), 1);
        repeat (4) begin
          @(negedge clk);
          chk("stall_valid", DATA_W'(o_tx_valid), 1);
          chk("stall_data", o_tx_data, held);
        end
        @(posedge clk); #1 i_tx_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(o_tx_valid && o_tx_endofpacket) && n < 50);
        @(negedge clk);
        chk("pkt2_sop_follows", DATA_W'({o_tx_valid, o_tx_startofpacket}), 2'b11);
      end
    join
    idle(1);
    drain();
`ifdef ETH_TX_SF_STATS_EN
    chk("frames_after_3", DATA_W'(o_tx_frames), 3);
`else
    chk("frames_tied_0", DATA_W'(o_tx_frames), 0);
`endif

    // 20-beat packet truncated to 16 words; next packet intact
    for (int k = 0; k < 16; k++)
      push(100 + k, k == 0, k == 15, 0, k == 15);
    push(200, 1, 0, 0, 0); push(201, 0, 1, 3, 0);
    for (int k = 0; k < 20; k++)
      send(100 + k, k == 0, k == 19, (k == 19) ? 6'd7 : 6'd0, 0);
    send(200, 1, 0, 0, 0); send(201, 0, 1, 3, 0);
    drain();
    chk("ovf_drop", DATA_W'(o_drop_count), 4);

    // non-SOP beat while idle
    do_reset();
    idle(1);
    send(50, 0, 1, 0, 0);
    repeat (4) begin @(negedge clk); chk("nonsop_no_out", DATA_W'(o_tx_valid), 0); end
    chk("nonsop_drop", DATA_W'(o_drop_count), 1);
    @(posedge clk); #1;

    // SOP inside a packet after 2 beats
    push(300, 1, 0, 0, 0); push(301, 0, 1, 0, 1);
    send(300, 1, 0, 0, 0); send(301, 0, 0, 0, 0);
    send(302, 1, 0, 0, 0); send(303, 0, 0, 0, 0); send(304, 0, 1, 4, 0);
    drain();
    chk("sopin_drop", DATA_W'(o_drop_count), 4);

    // reset while sending
    push(400, 1, 0, 0, 0); push(401, 0, 0, 0, 0); push(402, 0, 0, 0, 0); push(403, 0, 1, 0, 0);
    send(400, 1, 0, 0, 0); send(401, 0, 0, 0, 0); send(402, 0, 0, 0, 0); send(403, 0, 1, 0, 0);
    wait_sop();
    @(posedge clk); #1 i_tx_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rsend_rst_valid", DATA_W'(o_tx_valid), 0);
    chk("rsend_rst_drop", DATA_W'(o_drop_count), 0);
    chk("rsend_rst_frames", DATA_W'(o_tx_frames), 0);
    @(posedge clk); #1 i_tx_reset = 1'b0;
    sb.delete();
    repeat (5) begin @(negedge clk); chk("post_rst_idle", DATA_W'(o_tx_valid), 0); end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
